// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int ADDR_W_DEF = 18;

  // Outstanding read: valid bit plus the port that issued it
  typedef struct packed {
    logic vld;
    logic port;
  } rd_owner_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and data_memory signals of the arbiter, bundled in one interface.
interface dmem_port_arbiter_if #(parameter int ADDR_W = 18);
  logic              p0_req;
  logic              p0_we;
  logic [3:0]        p0_be;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;

  logic              p1_req;
  logic              p1_we;
  logic [3:0]        p1_be;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata;
  logic              p1_lock;
  logic              p1_gnt;
  logic              p1_rvalid;

  logic [31:0]       rdata;
  logic              mem_write;
  logic [3:0]        mem_byte_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_read_data;

  modport slave (
    input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_lock,
    input  mem_read_data,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    output mem_write, mem_byte_en, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_lock,
    output mem_read_data,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    input  mem_write, mem_byte_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// 4-bit saturating counter. clr and inc together load 1 (start a new count
// with the current event already counted).
module arb_sat_counter #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam logic [3:0] MAX4 = 4'(MAX);

  logic [3:0] cnt;

  // count register: clear/load-1, increment, hold at MAX
  always_ff @(posedge clk) begin
    if (rst)              cnt <= 4'd0;
    else if (clr)         cnt <= inc ? 4'd1 : 4'd0;
    else if (inc && !sat) cnt <= cnt + 4'd1;
  end

  assign sat = (cnt == MAX4);
endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data_memory.
// Port 0 (CPU) wins by default; port 1 ages into priority after MAX_WAIT
// denied cycles and may lock the memory for at most LOCK_MAX beats.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input logic          clk,
  input logic          rst,
  dmem_port_arbiter_if.slave bus
);
  arb_state_e        state, state_nxt;
  logic              pri0_once, pri0_nxt;
  rd_owner_t         rd_owner;
  logic              g0, g1;
  logic              wait_sat, cap_hit;
  logic              lock_clr, lock_inc;
  logic [ADDR_W-1:0] addr_mux;

  // Aging: counts denied port-1 cycles, cleared by any port-1 grant
  arb_sat_counter #(.MAX(MAX_WAIT)) u_wait (
    .clk(clk), .rst(rst),
    .clr(g1), .inc(bus.p1_req && !g1),
    .sat(wait_sat)
  );

  // Lock beats. The counter saturates at LOCK_MAX-1 so sat means "this beat
  // is the last one allowed". It is held at 0 in ARB, which also makes sat
  // true there when LOCK_MAX==1 (a single-beat lock never enters LOCK1).
  assign lock_inc = g1 && bus.p1_lock && !cap_hit;
  assign lock_clr = (state == ARB) || (g1 && !lock_inc);

  arb_sat_counter #(.MAX(LOCK_MAX - 1)) u_lock (
    .clk(clk), .rst(rst),
    .clr(lock_clr), .inc(lock_inc),
    .sat(cap_hit)
  );

  // State, one-shot port-0 priority and outstanding-read owner
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      pri0_once <= 1'b0;
      rd_owner  <= '0;
    end else begin
      state         <= state_nxt;
      pri0_once     <= pri0_nxt;
      rd_owner.vld  <= (g0 && !bus.p0_we) || (g1 && !bus.p1_we);
      rd_owner.port <= g1 ? P1 : P0;
    end
  end

  // Grant decision and next state; nothing is granted while in reset
  always_comb begin
    state_nxt = state;
    pri0_nxt  = pri0_once;
    g0        = 1'b0;
    g1        = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (bus.p0_req && bus.p1_req) begin
            if (wait_sat && !pri0_once) g1 = 1'b1;
            else                        g0 = 1'b1;
            pri0_nxt = 1'b0;
          end else begin
            g0 = bus.p0_req;
            g1 = bus.p1_req;
          end
          if (g1 && bus.p1_lock && !cap_hit) state_nxt = LOCK1;
        end
        LOCK1: begin
          // port 0 stays out for the whole lock, even on idle port-1 cycles
          g1 = bus.p1_req;
          if (g1 && (!bus.p1_lock || cap_hit)) state_nxt = ARB;
        end
        default: state_nxt = ARB;
      endcase
      // lock cut short by the beat cap: hand port 0 the next conflict
      if (g1 && bus.p1_lock && cap_hit) pri0_nxt = 1'b1;
    end
  end

  // Memory-side mux; idle cycles park the address/data on port 0
  assign addr_mux        = g1 ? bus.p1_addr : bus.p0_addr;
  assign bus.mem_addr    = addr_mux;
  assign bus.mem_wdata   = g1 ? bus.p1_wdata : bus.p0_wdata;
  assign bus.mem_write   = g1 ? bus.p1_we : (g0 ? bus.p0_we : 1'b0);
  assign bus.mem_byte_en = g1 ? bus.p1_be : (g0 ? bus.p0_be : 4'd0);

  assign bus.p0_gnt    = g0;
  assign bus.p1_gnt    = g1;
  assign bus.p0_rvalid = rd_owner.vld && (rd_owner.port == P0) && !rst;
  assign bus.p1_rvalid = rd_owner.vld && (rd_owner.port == P1) && !rst;
  assign bus.rdata     = bus.mem_read_data;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small behavioural data_memory.
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  localparam logic [17:0] A0 = 18'h40;
  localparam logic [17:0] A1 = 18'h44;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(18)) bus ();

  dmem_port_arbiter #(.ADDR_W(18), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // data_memory: synchronous read, byte-enable write
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_write)
      for (int b = 0; b < 4; b++)
        if (bus.mem_byte_en[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    bus.mem_read_data <= mem[bus.mem_addr[9:2]];
  end

  typedef struct packed {
    logic rst, p0r, p0w, p1r, p1w, p1l;
    logic e0g, e1g, e0v, e1v, emw;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic r, p0r, p0w, p1r, p1w, p1l,
                              input logic e0g, e1g, e0v, e1v, emw);
    vecs.push_back('{r, p0r, p0w, p1r, p1w, p1l, e0g, e1g, e0v, e1v, emw});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic p0(input logic req, we, input logic [3:0] be, input logic [17:0] a, input logic [31:0] d);
    bus.p0_req = req; bus.p0_we = we; bus.p0_be = be; bus.p0_addr = a; bus.p0_wdata = d;
  endtask

  task automatic p1(input logic req, we, lock, input logic [3:0] be, input logic [17:0] a, input logic [31:0] d);
    bus.p1_req = req; bus.p1_we = we; bus.p1_lock = lock; bus.p1_be = be; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  task automatic idle();
    p0(1'b0, 1'b0, 4'h0, 18'h0, 32'h0);
    p1(1'b0, 1'b0, 1'b0, 4'h0, 18'h0, 32'h0);
  endtask

  initial begin
    idle();
    // reset with requests pending: nothing granted
    add(1,1,1,1,1,0, 0,0,0,0,0);
    add(1,1,1,1,1,0, 0,0,0,0,0);
    // continuous conflict: p1 denied 4 cycles, granted on the 5th, repeat
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) add(0,1,1,1,1,0, 1,0,0,0,1);
      add(0,1,1,1,1,0, 0,1,0,0,1);
    end
    add(0,0,0,0,0,0, 0,0,0,0,0);
    // 12-beat locked burst, cap 8, p0 waiting with one write
    add(0,0,0,1,1,1, 0,1,0,0,1);
    for (int i = 0; i < 7; i++) add(0,1,1,1,1,1, 0,1,0,0,1);
    add(0,1,1,1,1,1, 1,0,0,0,1);
    for (int i = 0; i < 3; i++) add(0,0,0,1,1,1, 0,1,0,0,1);
    add(0,0,0,1,1,0, 0,1,0,0,1);
    add(0,0,0,0,0,0, 0,0,0,0,0);
    // lock held while p1 idles 2 cycles; exit beat collides with p0
    add(0,0,0,1,1,1, 0,1,0,0,1);
    add(0,1,1,0,0,1, 0,0,0,0,0);
    add(0,1,1,0,0,1, 0,0,0,0,0);
    add(0,1,1,1,1,0, 0,1,0,0,1);
    add(0,1,1,0,0,0, 1,0,0,0,1);
    add(0,0,0,0,0,0, 0,0,0,0,0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      p0(vecs[i].p0r, vecs[i].p0w, 4'hF, A0, 32'h0000_0A00 + i);
      p1(vecs[i].p1r, vecs[i].p1w, vecs[i].p1l, 4'hF, A1, 32'h0000_0B00 + i);
      #1;
      chk($sformatf("v%0d_p0_gnt", i),    32'(bus.p0_gnt),    32'(vecs[i].e0g));
      chk($sformatf("v%0d_p1_gnt", i),    32'(bus.p1_gnt),    32'(vecs[i].e1g));
      chk($sformatf("v%0d_p0_rvalid", i), 32'(bus.p0_rvalid), 32'(vecs[i].e0v));
      chk($sformatf("v%0d_p1_rvalid", i), 32'(bus.p1_rvalid), 32'(vecs[i].e1v));
      chk($sformatf("v%0d_mem_write", i), 32'(bus.mem_write), 32'(vecs[i].emw));
      chk($sformatf("v%0d_mem_addr", i),  32'(bus.mem_addr),  32'(vecs[i].e1g ? A1 : A0));
    end

    // single p0 write then read of 0x10
    @(negedge clk); idle(); p0(1, 1, 4'hF, 18'h10, 32'hDEADBEEF); #1;
    chk("e_wr_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("e_wr_data", bus.mem_wdata, 32'hDEADBEEF);
    chk("e_wr_be", 32'(bus.mem_byte_en), 32'hF);
    @(negedge clk); p0(1, 0, 4'h0, 18'h10, 32'h0); #1;
    chk("e_rd_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("e_rd_write", 32'(bus.mem_write), 32'd0);
    chk("e_rd_addr", 32'(bus.mem_addr), 32'h10);
    @(negedge clk); idle(); #1;
    chk("e_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("e_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("e_rdata", bus.rdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("e_rvalid_drop", 32'(bus.p0_rvalid), 32'd0);
    // partial write then immediate read
    @(negedge clk); p0(1, 1, 4'b0011, 18'h10, 32'h0000_1234); #1;
    @(negedge clk); p0(1, 0, 4'h0, 18'h10, 32'h0); #1;
    @(negedge clk); idle(); #1;
    chk("be_rdata", bus.rdata, 32'hDEAD1234);

    // preload via p1, then alternating reads p0@4, p1@8, p0@C
    @(negedge clk); p1(1, 1, 0, 4'hF, 18'h4, 32'h1111_1111); #1;
    chk("f_p1_wr_gnt", 32'(bus.p1_gnt), 32'd1);
    @(negedge clk); p1(1, 1, 0, 4'hF, 18'h8, 32'h2222_2222);
    @(negedge clk); p1(1, 1, 0, 4'hF, 18'hC, 32'h3333_3333);
    @(negedge clk); idle(); p0(1, 0, 4'h0, 18'h4, 32'h0); #1;
    chk("f_c0_p0_gnt", 32'(bus.p0_gnt), 32'd1);
    @(negedge clk); idle(); p1(1, 0, 0, 4'h0, 18'h8, 32'h0); #1;
    chk("f_c1_p1_gnt", 32'(bus.p1_gnt), 32'd1);
    chk("f_c1_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("f_c1_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("f_c1_rdata", bus.rdata, 32'h1111_1111);
    @(negedge clk); idle(); p0(1, 0, 4'h0, 18'hC, 32'h0); #1;
    chk("f_c2_p0_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("f_c2_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    chk("f_c2_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
    chk("f_c2_rdata", bus.rdata, 32'h2222_2222);
    @(negedge clk); idle(); #1;
    chk("f_c3_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("f_c3_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("f_c3_rdata", bus.rdata, 32'h3333_3333);
    @(negedge clk); #1;
    chk("f_c4_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);

    // reset one cycle after a locked p1 read grant
    @(negedge clk); p1(1, 0, 1, 4'h0, 18'h8, 32'h0); #1;
    chk("g_p1_gnt", 32'(bus.p1_gnt), 32'd1);
    @(negedge clk); rst = 1'b1; p0(1, 0, 4'h0, 18'h4, 32'h0); #1;
    chk("g_rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("g_rst_gnts", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd0);
    chk("g_rst_mem_write", 32'(bus.mem_write), 32'd0);
    @(negedge clk); rst = 1'b0; p1(1, 0, 0, 4'h0, 18'h8, 32'h0); #1;
    chk("g_post_p0_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("g_post_p1_gnt", 32'(bus.p1_gnt), 32'd0);
    @(negedge clk); idle(); #1;
    chk("g_post_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("g_post_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("g_post_rdata", bus.rdata, 32'h1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
